lane_hit_judge: RTL and testbench

- Consumes the falling-block heights of one piano lane and the lane's key, and judges every key press against the blocks.
- Produces per-press hit/perfect/bad pulses, per-block miss pulses, a hide mask for the display, and lane hit/miss counts for the score stage.
- Sits directly downstream of the lane's block height generators; runs on the same clock (one pixel of block motion per cycle).

---
 rtl/lane_hit_judge_pkg.sv | 36 +++
 rtl/lane_block_tracker.sv | 78 +++++++
 rtl/lane_hit_judge.sv | 137 +++++++++++++
 tb/tb_lane_hit_judge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_hit_judge_pkg.sv
// Shared types and constants for the piano-lane hit judge: block state
// encoding, judging windows, well-known heights and the saturating counter helper.
package lane_hit_judge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_HIT    = 2'd2,
        ST_MISSED = 2'd3
    } blk_state_e;

    localparam int unsigned H_W   = 10;
    localparam int unsigned CNT_W = 7;

    localparam logic [H_W-1:0] DEF_HIT_LO  = 10'd560;
    localparam logic [H_W-1:0] DEF_HIT_HI  = 10'd660;
    localparam logic [H_W-1:0] DEF_PERF_LO = 10'd600;
    localparam logic [H_W-1:0] DEF_PERF_HI = 10'd630;
    localparam logic [H_W-1:0] SPAWN_H     = 10'd120;
    localparam logic [H_W-1:0] PARK_H      = 10'd720;

    localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

    // Counters stick at CNT_MAX instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        if (sum > {1'b0, CNT_MAX}) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lane_block_tracker.sv
// Tracks one falling block: remembers its previous height to spot respawns,
// runs the IDLE/ARMED/HIT/MISSED state machine and reports window flags.
module lane_block_tracker
    import lane_hit_judge_pkg::*;
#(
    parameter logic [H_W-1:0] HIT_LO  = DEF_HIT_LO,
    parameter logic [H_W-1:0] HIT_HI  = DEF_HIT_HI,
    parameter logic [H_W-1:0] PERF_LO = DEF_PERF_LO,
    parameter logic [H_W-1:0] PERF_HI = DEF_PERF_HI
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart_i,
    input  logic           stop_i,
    input  logic [H_W-1:0] block_h_i,
    input  logic           select_i,
    output logic           cand_o,
    output logic           perf_o,
    output logic           miss_o,
    output logic           hide_o
);

    blk_state_e     state_q, state_d;
    logic [H_W-1:0] prev_h_q, prev_h_d;
    logic           hide_q, hide_d;
    logic           respawn_s;
    logic           armed_s;
    logic           in_win_s;

    // A height that drops below last cycle's value means the generator respawned.
    assign respawn_s = block_h_i < prev_h_q;
    assign armed_s   = (state_q == ST_ARMED) && !respawn_s;
    assign in_win_s  = (block_h_i >= HIT_LO) && (block_h_i <= HIT_HI);
    assign cand_o    = armed_s && in_win_s;
    assign perf_o    = (block_h_i >= PERF_LO) && (block_h_i <= PERF_HI);
    assign miss_o    = armed_s && (block_h_i > HIT_HI) && !stop_i;
    assign hide_o    = hide_q;

    // Next-state logic: restart beats respawn, respawn beats hit/miss.
    always_comb begin
        state_d  = state_q;
        prev_h_d = block_h_i;
        if (restart_i) begin
            state_d = ST_IDLE;
        end else if (respawn_s) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (select_i) begin
                        state_d = ST_HIT;
                    end else if (miss_o) begin
                        state_d = ST_MISSED;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_IDLE, ST_HIT, ST_MISSED: state_d = state_q;
                default:                    state_d = ST_IDLE;
            endcase
        end
        hide_d = (state_d == ST_HIT);
    end

    // State, height history and hide flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prev_h_q <= 10'd0;
            hide_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_h_q <= prev_h_d;
            hide_q   <= hide_d;
        end
    end

endmodule

// File: rtl/lane_hit_judge.sv
// Judges key presses of one piano lane against its falling blocks and produces
// registered hit/perfect/bad/miss pulses, the hide mask and saturating counts.
module lane_hit_judge
    import lane_hit_judge_pkg::*;
#(
    parameter int unsigned     NBLK    = 4,
    parameter logic [H_W-1:0]  HIT_LO  = DEF_HIT_LO,
    parameter logic [H_W-1:0]  HIT_HI  = DEF_HIT_HI,
    parameter logic [H_W-1:0]  PERF_LO = DEF_PERF_LO,
    parameter logic [H_W-1:0]  PERF_HI = DEF_PERF_HI
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  stop_or_endgame,
    input  logic                  key,
    input  logic [NBLK*H_W-1:0]   block_h_bus,
    output logic                  hit_pulse,
    output logic                  perfect_pulse,
    output logic                  bad_pulse,
    output logic                  miss_pulse,
    output logic [NBLK-1:0]       hide_mask,
    output logic [CNT_W-1:0]      lane_hits,
    output logic [CNT_W-1:0]      lane_misses
);

    logic [NBLK-1:0][H_W-1:0] h_s;
    logic [NBLK-1:0]          cand_s, perf_s, miss_s, sel_s;
    logic [NBLK-1:0]          best_oh_s;
    logic [H_W-1:0]           best_h_s;
    logic                     found_s, best_perf_s, press_s;
    logic [CNT_W-1:0]         miss_cnt_s;

    logic             key_q, key_d;
    logic             hit_q, hit_d, perf_q, perf_d, bad_q, bad_d, miss_q, miss_d;
    logic [CNT_W-1:0] hits_q, hits_d, misses_q, misses_d;

    assign h_s     = block_h_bus;
    assign press_s = key && !key_q && !stop_or_endgame;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        lane_block_tracker #(
            .HIT_LO  (HIT_LO),
            .HIT_HI  (HIT_HI),
            .PERF_LO (PERF_LO),
            .PERF_HI (PERF_HI)
        ) u_trk (
            .clk       (clk),
            .rst_n     (rst_n),
            .restart_i (restart),
            .stop_i    (stop_or_endgame),
            .block_h_i (h_s[g]),
            .select_i  (sel_s[g]),
            .cand_o    (cand_s[g]),
            .perf_o    (perf_s[g]),
            .miss_o    (miss_s[g]),
            .hide_o    (hide_mask[g])
        );
    end

    // Lowest candidate on screen wins; strict compare keeps the lowest index on ties.
    always_comb begin
        found_s     = 1'b0;
        best_h_s    = 10'd0;
        best_oh_s   = '0;
        best_perf_s = 1'b0;
        miss_cnt_s  = 7'd0;
        for (int i = 0; i < NBLK; i++) begin
            if (cand_s[i] && (!found_s || (h_s[i] > best_h_s))) begin
                found_s      = 1'b1;
                best_h_s     = h_s[i];
                best_oh_s    = '0;
                best_oh_s[i] = 1'b1;
                best_perf_s  = perf_s[i];
            end else begin
                found_s = found_s;
            end
            miss_cnt_s = miss_cnt_s + {{(CNT_W-1){1'b0}}, miss_s[i]};
        end
        if (press_s) begin
            sel_s = best_oh_s;
        end else begin
            sel_s = '0;
        end
    end

    // Next values of pulses, counters and key history; restart clears everything.
    always_comb begin
        key_d    = key;
        hit_d    = press_s && found_s;
        perf_d   = press_s && found_s && best_perf_s;
        bad_d    = press_s && !found_s;
        miss_d   = |miss_s;
        hits_d   = sat_add(hits_q, {{(CNT_W-1){1'b0}}, press_s && found_s});
        misses_d = sat_add(misses_q, miss_cnt_s);
        if (restart) begin
            key_d    = 1'b0;
            hit_d    = 1'b0;
            perf_d   = 1'b0;
            bad_d    = 1'b0;
            miss_d   = 1'b0;
            hits_d   = 7'd0;
            misses_d = 7'd0;
        end else begin
            key_d = key;
        end
    end

    // Output and key-edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= 1'b0;
            hit_q    <= 1'b0;
            perf_q   <= 1'b0;
            bad_q    <= 1'b0;
            miss_q   <= 1'b0;
            hits_q   <= 7'd0;
            misses_q <= 7'd0;
        end else begin
            key_q    <= key_d;
            hit_q    <= hit_d;
            perf_q   <= perf_d;
            bad_q    <= bad_d;
            miss_q   <= miss_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign hit_pulse     = hit_q;
    assign perfect_pulse = perf_q;
    assign bad_pulse     = bad_q;
    assign miss_pulse    = miss_q;
    assign lane_hits     = hits_q;
    assign lane_misses   = misses_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Directed bench for lane_hit_judge: hand-computed pulses, mask and counts.
module tb_lane_hit_judge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        stop_or_endgame;
    logic        key;
    logic [39:0] block_h_bus;
    logic        hit_pulse, perfect_pulse, bad_pulse, miss_pulse;
    logic [3:0]  hide_mask;
    logic [6:0]  lane_hits, lane_misses;

    logic [9:0]  h [4];
    int          checks   = 0;
    int          failures = 0;
    int          extra_hits;

    lane_hit_judge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .key             (key),
        .block_h_bus     (block_h_bus),
        .hit_pulse       (hit_pulse),
        .perfect_pulse   (perfect_pulse),
        .bad_pulse       (bad_pulse),
        .miss_pulse      (miss_pulse),
        .hide_mask       (hide_mask),
        .lane_hits       (lane_hits),
        .lane_misses     (lane_misses)
    );

    always #5 clk = ~clk;

    task automatic tick();
        block_h_bus = {h[3], h[2], h[1], h[0]};
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses packed as {hit, perfect, bad, miss}.
    task automatic chk_p(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, hit_pulse, perfect_pulse, bad_pulse, miss_pulse}, {28'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0; key = 1'b0;
        for (int i = 0; i < 4; i++) h[i] = 10'd720;
        tick(); tick();
        chk_p("reset_pulses", 4'b0000);
        chk("reset_hide", 32'(hide_mask), 32'd0);
        chk("reset_hits", 32'(lane_hits), 32'd0);
        chk("reset_misses", 32'(lane_misses), 32'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk_p("parked_idle_no_miss", 4'b0000);

        // Perfect hit at 615
        h[0] = 10'd120; tick();
        h[0] = 10'd615; tick();
        key = 1'b1; tick();
        chk_p("perfect_hit", 4'b1100);
        chk("perfect_hide", 32'(hide_mask), 32'd1);
        chk("perfect_hits", 32'(lane_hits), 32'd1);
        key = 1'b0; tick();
        chk_p("pulse_one_cycle", 4'b0000);

        // Plain hit at 570, then a held key
        h[0] = 10'd120; tick();
        chk("respawn_unhides", 32'(hide_mask), 32'd0);
        h[0] = 10'd570; tick();
        key = 1'b1; tick();
        chk_p("plain_hit", 4'b1000);
        chk("plain_hits", 32'(lane_hits), 32'd2);
        extra_hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hit_pulse || bad_pulse) extra_hits++;
        end
        chk("held_key_single_press", 32'(extra_hits), 32'd0);
        key = 1'b0; h[0] = 10'd700; tick();
        chk_p("hit_block_never_missed", 4'b0000);

        // Miss boundary 660 / 661
        h[0] = 10'd120; tick();
        h[0] = 10'd660; tick();
        chk_p("h660_no_miss", 4'b0000);
        h[0] = 10'd661; tick();
        chk_p("h661_miss", 4'b0001);
        chk("miss_count1", 32'(lane_misses), 32'd1);
        h[0] = 10'd662; tick();
        chk_p("miss_one_cycle", 4'b0000);
        key = 1'b1; tick();
        chk_p("press_on_missed_bad", 4'b0010);
        key = 1'b0; h[0] = 10'd120; tick();
        h[0] = 10'd600; tick();
        key = 1'b1; tick();
        chk_p("rearmed_hit_perf600", 4'b1100);
        chk("hits3", 32'(lane_hits), 32'd3);
        key = 1'b0;

        // Two blocks: lower one first, then the other
        h[0] = 10'd120; h[2] = 10'd120; tick();
        h[0] = 10'd640; h[2] = 10'd580; tick();
        key = 1'b1; tick();
        chk_p("pick_lowest_block", 4'b1000);
        chk("pick_hide0", 32'(hide_mask), 32'd1);
        key = 1'b0; h[0] = 10'd650; h[2] = 10'd590; tick();
        key = 1'b1; tick();
        chk_p("second_press_blk2", 4'b1000);
        chk("second_hide", 32'(hide_mask), 32'd5);
        chk("hits5", 32'(lane_hits), 32'd5);

        // Tie goes to lowest index
        key = 1'b0; h[0] = 10'd120; h[2] = 10'd120; tick();
        h[0] = 10'd620; h[2] = 10'd620; tick();
        key = 1'b1; tick();
        chk("tie_hide", 32'(hide_mask), 32'd1);
        key = 1'b0; tick();
        key = 1'b1; tick();
        chk_p("tie_second_perf", 4'b1100);
        chk("tie_hide_both", 32'(hide_mask), 32'd5);
        key = 1'b0; h[0] = 10'd720; h[2] = 10'd720; tick();
        chk_p("hit_blocks_park_no_miss", 4'b0000);

        // Bad press leaves the block armed
        h[1] = 10'd120; tick();
        h[1] = 10'd300; tick();
        key = 1'b1; tick();
        chk_p("bad_press", 4'b0010);
        chk("bad_no_hit_count", 32'(lane_hits), 32'd7);
        key = 1'b0; h[1] = 10'd615; tick();
        key = 1'b1; tick();
        chk_p("after_bad_hit", 4'b1100);
        chk("after_bad_hide", 32'(hide_mask), 32'd7);
        key = 1'b0;

        // Stop freezes presses and misses
        h[3] = 10'd120; tick();
        h[3] = 10'd615; tick();
        stop_or_endgame = 1'b1; key = 1'b1; tick();
        chk_p("stop_press_ignored", 4'b0000);
        key = 1'b0; h[3] = 10'd700; tick();
        chk_p("stop_no_miss", 4'b0000);
        chk("stop_misses", 32'(lane_misses), 32'd1);
        stop_or_endgame = 1'b0; tick();
        chk_p("unstop_miss", 4'b0001);
        chk("misses2", 32'(lane_misses), 32'd2);

        // Hit plus two simultaneous misses
        h[0] = 10'd120; h[1] = 10'd120; h[3] = 10'd120; tick();
        chk("combo_hide_reset", 32'(hide_mask), 32'd4);
        h[0] = 10'd615; h[1] = 10'd661; h[3] = 10'd661; key = 1'b1; tick();
        chk_p("hit_and_double_miss", 4'b1101);
        chk("double_miss_count", 32'(lane_misses), 32'd4);
        chk("combo_hits", 32'(lane_hits), 32'd9);
        key = 1'b0; tick();

        // Saturation
        for (int i = 0; i < 130; i++) begin
            h[0] = 10'd120; tick();
            h[0] = 10'd615; tick();
            key = 1'b1; tick();
            chk_p("sat_loop_hit", 4'b1100);
            key = 1'b0; tick();
        end
        chk("hits_saturate", 32'(lane_hits), 32'd127);
        chk("misses_unchanged", 32'(lane_misses), 32'd4);

        // Restart mid-fall
        h[0] = 10'd120; tick();
        h[0] = 10'd500; tick();
        restart = 1'b1; tick();
        restart = 1'b0;
        chk_p("restart_pulses", 4'b0000);
        chk("restart_hide", 32'(hide_mask), 32'd0);
        chk("restart_hits", 32'(lane_hits), 32'd0);
        chk("restart_misses", 32'(lane_misses), 32'd0);
        h[0] = 10'd615; key = 1'b1; tick();
        chk_p("restart_idle_not_judged", 4'b0010);
        key = 1'b0; h[0] = 10'd720; tick();
        chk_p("restart_idle_no_miss", 4'b0000);
        h[0] = 10'd120; tick();
        h[0] = 10'd615; tick();
        key = 1'b1; tick();
        chk_p("post_restart_hit", 4'b1100);
        chk("post_restart_hits", 32'(lane_hits), 32'd1);
        key = 1'b0;

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_hide", 32'(hide_mask), 32'd0);
        chk("async_hits", 32'(lane_hits), 32'd0);
        chk_p("async_pulses", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
